// File: rtl/instruction_encoder_loader_pkg.sv
// Shared field widths, format constants and FSM states for the instruction encoder/loader.
// Must stay in step with the field layout used by decode_instruction.
package instruction_encoder_loader_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int OPCODE_SIZE    = 4;
    localparam int REG_ADDR_SIZE  = 3;
    localparam int SMALL_IMM_SIZE = 6;
    localparam int BIG_IMM_SIZE   = 9;

    localparam logic FMT_SMALL = 1'b0;
    localparam logic FMT_BIG   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/instruction_encoder_loader_if.sv
// Field-tuple stream into the loader: valid/ready/last plus instruction fields.
// master = program source, slave = loader.
interface instruction_encoder_loader_if;
    import instruction_encoder_loader_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic                      in_last;
    logic [OPCODE_SIZE-1:0]    in_opcode;
    logic [REG_ADDR_SIZE-1:0]  in_reg_dest;
    logic [REG_ADDR_SIZE-1:0]  in_reg_src;
    logic [SMALL_IMM_SIZE-1:0] in_small_imm;
    logic [BIG_IMM_SIZE-1:0]   in_big_imm;
    logic                      in_use_big;

    modport master (
        output in_valid, in_last, in_opcode, in_reg_dest,
        output in_reg_src, in_small_imm, in_big_imm, in_use_big,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, in_opcode, in_reg_dest,
        input  in_reg_src, in_small_imm, in_big_imm, in_use_big,
        output in_ready
    );

endinterface

// File: rtl/instruction_encoder_loader_pack.sv
// pack_instruction: combinational field-to-word packer, inverse of decode_instruction.
// Small format {op, rd, rs, simm}; big format {op, rd, bimm}.
module pack_instruction
    import instruction_encoder_loader_pkg::*;
(
    input  logic [OPCODE_SIZE-1:0]    opcode,
    input  logic [REG_ADDR_SIZE-1:0]  reg_dest,
    input  logic [REG_ADDR_SIZE-1:0]  reg_src,
    input  logic [SMALL_IMM_SIZE-1:0] small_imm,
    input  logic [BIG_IMM_SIZE-1:0]   big_imm,
    input  logic                      use_big,
    output logic [WORD_SIZE-1:0]      word
);

    always_comb begin
        word = {opcode, reg_dest, reg_src, small_imm};
        if (use_big == FMT_BIG) begin
            word = {opcode, reg_dest, big_imm};
        end
    end

endmodule

// File: rtl/instruction_encoder_loader.sv
// Packs streamed instruction fields and writes them to imem from address 0.
// ENCODER_FIELD_CHECK_EN: big-format tuples with nonzero rs are consumed unwritten and set err.
module instruction_encoder_loader
    import instruction_encoder_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    instruction_encoder_loader_if.slave src,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  err
);

    localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_t               state_q;
    state_t               state_d;
    logic                 accept;
    logic                 illegal;
    logic                 write;
    logic                 at_end;
    logic                 clear;
    logic [WORD_SIZE-1:0] word;

    pack_instruction u_pack (
        .opcode    (src.in_opcode),
        .reg_dest  (src.in_reg_dest),
        .reg_src   (src.in_reg_src),
        .small_imm (src.in_small_imm),
        .big_imm   (src.in_big_imm),
        .use_big   (src.in_use_big),
        .word      (word)
    );

    assign src.in_ready = (state_q == LOAD);
    assign accept       = src.in_valid & src.in_ready;

`ifdef ENCODER_FIELD_CHECK_EN
    assign illegal = src.in_use_big & (src.in_reg_src != '0);
`else
    assign illegal = 1'b0;
`endif

    assign write  = accept & ~illegal;
    // Writing the top address fills memory; the load must stop there.
    assign at_end = write & (count == LAST_IDX);
    assign clear  = start & (state_q != LOAD);
    assign busy   = (state_q == LOAD);
    assign done   = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (accept & (src.in_last | at_end)) state_d = DONE;
            DONE:    if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            full      <= 1'b0;
        end else begin
            mem_we <= write;
            if (clear) begin
                count <= '0;
                full  <= 1'b0;
            end
            if (write) begin
                mem_addr  <= count[ADDR_WIDTH-1:0];
                mem_wdata <= word;
                count     <= count + 1'b1;
            end
            if (at_end) begin
                full <= 1'b1;
            end
        end
    end

`ifdef ENCODER_FIELD_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (clear) begin
            err <= 1'b0;
        end else if (accept & illegal) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Scoreboard bench: expected writes queued at accept, popped when mem_we is seen.
// Runs an ADDR_WIDTH=8 instance and an ADDR_WIDTH=2 instance for the full-memory case.
module tb_instruction_encoder_loader;
    import instruction_encoder_loader_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic start_a;
    logic start_b;

    always #5 clk = ~clk;

    instruction_encoder_loader_if if_a ();
    instruction_encoder_loader_if if_b ();

    logic                 we_a, busy_a, done_a, full_a, err_a;
    logic [7:0]           addr_a;
    logic [WORD_SIZE-1:0] wdata_a;
    logic [8:0]           cnt_a;
    logic                 we_b, busy_b, done_b, full_b, err_b;
    logic [1:0]           addr_b;
    logic [WORD_SIZE-1:0] wdata_b;
    logic [2:0]           cnt_b;

    instruction_encoder_loader #(.ADDR_WIDTH(8)) u_dut (
        .clk(clk), .reset(reset), .start(start_a), .src(if_a),
        .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .busy(busy_a), .done(done_a), .count(cnt_a),
        .full(full_a), .err(err_a)
    );

    instruction_encoder_loader #(.ADDR_WIDTH(2)) u_small (
        .clk(clk), .reset(reset), .start(start_b), .src(if_b),
        .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .busy(busy_b), .done(done_b), .count(cnt_b),
        .full(full_b), .err(err_b)
    );

    int n_run  = 0;
    int n_fail = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    int exp_a = 0;
    int exp_b = 0;
    logic [31:0] e_a;
    logic [31:0] e_b;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op,
        input logic [2:0] rd, input logic [2:0] rs,
        input logic [5:0] si, input logic [8:0] bi, input bit ub);
        return ub ? {op, rd, bi} : {op, rd, rs, si};
    endfunction

    always @(negedge clk) begin
        if (we_a === 1'b1) begin
            if (q_a.size() == 0) begin
                check("a_spurious_we", 1, 0);
            end else begin
                e_a = q_a.pop_front();
                check("a_addr", {24'd0, addr_a}, e_a[31:16]);
                check("a_data", {16'd0, wdata_a}, e_a[15:0]);
            end
        end
        if (we_b === 1'b1) begin
            if (q_b.size() == 0) begin
                check("b_spurious_we", 1, 0);
            end else begin
                e_b = q_b.pop_front();
                check("b_addr", {30'd0, addr_b}, e_b[31:16]);
                check("b_data", {16'd0, wdata_b}, e_b[15:0]);
            end
        end
    end

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        if (sel) exp_b = 0; else exp_a = 0;
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic send(input bit sel, input logic [3:0] op,
        input logic [2:0] rd, input logic [2:0] rs,
        input logic [5:0] si, input logic [8:0] bi,
        input bit ub, input bit last, input bit exp_wr);
        bit ok;
        logic [15:0] w;
        w = enc(op, rd, rs, si, bi, ub);
        if (sel) begin
            if_b.in_opcode = op; if_b.in_reg_dest = rd;
            if_b.in_reg_src = rs; if_b.in_small_imm = si;
            if_b.in_big_imm = bi; if_b.in_use_big = ub;
            if_b.in_last = last; if_b.in_valid = 1'b1;
        end else begin
            if_a.in_opcode = op; if_a.in_reg_dest = rd;
            if_a.in_reg_src = rs; if_a.in_small_imm = si;
            if_a.in_big_imm = bi; if_a.in_use_big = ub;
            if_a.in_last = last; if_a.in_valid = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if ((sel ? if_b.in_ready : if_a.in_ready) === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            if (exp_wr) begin
                if (sel) begin
                    q_b.push_back({16'(exp_b), w});
                    exp_b++;
                end else begin
                    q_a.push_back({16'(exp_a), w});
                    exp_a++;
                end
            end
        end else begin
            check("ready_timeout", 0, 1);
        end
        @(posedge clk);
        #1;
        if_a.in_valid = 1'b0;
        if_b.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        if_a.in_valid = 1'b0; if_a.in_last = 1'b0; if_a.in_opcode = '0;
        if_a.in_reg_dest = '0; if_a.in_reg_src = '0; if_a.in_small_imm = '0;
        if_a.in_big_imm = '0; if_a.in_use_big = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_last = 1'b0; if_b.in_opcode = '0;
        if_b.in_reg_dest = '0; if_b.in_reg_src = '0; if_b.in_small_imm = '0;
        if_b.in_big_imm = '0; if_b.in_use_big = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_we", we_a, 0);
        check("rst_addr", addr_a, 0);
        check("rst_wdata", wdata_a, 0);
        check("rst_count", cnt_a, 0);
        check("rst_done", done_a, 0);
        check("rst_full", full_a, 0);
        check("rst_err", err_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_ready", if_a.in_ready, 0);
        @(posedge clk);
        #1;

        // Single small-format word
        pulse_start(0);
        check("t1_busy", busy_a, 1);
        send(0, 4'h5, 3'd3, 3'd2, 6'h0A, 9'h0, 1'b0, 1'b1, 1'b1);
        check("t1_we", we_a, 1);
        check("t1_wdata", wdata_a, 16'h568A);
        check("t1_done", done_a, 1);
        check("t1_count", cnt_a, 1);

        // Single big-format word
        pulse_start(0);
        check("t2_done_clr", done_a, 0);
        send(0, 4'hC, 3'd1, 3'd0, 6'h0, 9'h1FF, 1'b1, 1'b1, 1'b1);
        check("t2_wdata", wdata_a, 16'hC3FF);
        check("t2_done", done_a, 1);

        // Back-to-back burst
        pulse_start(0);
        for (int i = 0; i < 4; i++) begin
            send(0, 4'(i + 1), 3'(i), 3'(7 - i), 6'(i * 9 + 3),
                 9'(i * 77), i[0], i == 3, 1'b1);
            check("t3_b2b_we", we_a, 1);
        end
        check("t3_count", cnt_a, 4);
        check("t3_done", done_a, 1);
        check("t3_full", full_a, 0);

        // Start during LOAD is ignored
        pulse_start(0);
        send(0, 4'h9, 3'd4, 3'd5, 6'h11, 9'h0, 1'b0, 1'b0, 1'b1);
        pulse_start(0);
        exp_a = 1;
        check("ign_start_cnt", cnt_a, 1);
        check("ign_start_busy", busy_a, 1);
        send(0, 4'hA, 3'd6, 3'd1, 6'h3F, 9'h0, 1'b0, 1'b1, 1'b1);
        check("ign_start_cnt2", cnt_a, 2);

        // Start with valid in DONE: only start acts
        if_a.in_valid = 1'b1;
        if_a.in_last = 1'b1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        if_a.in_valid = 1'b0;
        exp_a = 0;
        check("sv_count", cnt_a, 0);
        check("sv_done", done_a, 0);
        check("sv_busy", busy_a, 1);
        repeat (2) @(posedge clk);
        #1;
        send(0, 4'h3, 3'd2, 3'd2, 6'h05, 9'h0, 1'b0, 1'b1, 1'b1);
        check("sv_count2", cnt_a, 1);

        // Full memory on the ADDR_WIDTH=2 instance
        pulse_start(1);
        for (int i = 0; i < 4; i++) begin
            send(1, 4'(i + 8), 3'(i + 1), 3'(i), 6'(i * 5), 9'(i * 100),
                 1'b0, 1'b0, 1'b1);
        end
        check("t4_addr", addr_b, 3);
        check("t4_done", done_b, 1);
        check("t4_full", full_b, 1);
        check("t4_count", cnt_b, 4);
        check("t4_ready", if_b.in_ready, 0);
        if_b.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_no_ready", if_b.in_ready, 0);
        end
        @(posedge clk);
        #1;
        if_b.in_valid = 1'b0;
        check("t4_count_hold", cnt_b, 4);

        // Last and full on the same word
        pulse_start(1);
        check("lf_full_clr", full_b, 0);
        for (int i = 0; i < 4; i++) begin
            send(1, 4'hF, 3'(i), 3'd7, 6'h2A, 9'h0, 1'b0, i == 3, 1'b1);
        end
        check("lf_done", done_b, 1);
        check("lf_full", full_b, 1);

        // Reset right after an accept
        pulse_start(0);
        send(0, 4'h6, 3'd5, 3'd3, 6'h15, 9'h0, 1'b0, 1'b0, 1'b1);
        check("t5_we_pre", we_a, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_we", we_a, 0);
        check("t5_busy", busy_a, 0);
        check("t5_count", cnt_a, 0);
        check("t5_addr", addr_a, 0);
        check("t5_wdata", wdata_a, 0);
        check("t5_done", done_a, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Field check on big format with nonzero rs
        pulse_start(0);
`ifdef ENCODER_FIELD_CHECK_EN
        send(0, 4'h7, 3'd2, 3'd5, 6'h0, 9'h0AB, 1'b1, 1'b0, 1'b0);
        check("t6_we", we_a, 0);
        check("t6_count", cnt_a, 0);
        check("t6_err", err_a, 1);
        send(0, 4'h7, 3'd2, 3'd0, 6'h0, 9'h0AB, 1'b1, 1'b1, 1'b1);
        check("t6_err_sticky", err_a, 1);
        check("t6_count2", cnt_a, 1);
        pulse_start(0);
        check("t6_err_clr", err_a, 0);
        send(0, 4'h1, 3'd0, 3'd5, 6'h0, 9'h001, 1'b1, 1'b1, 1'b0);
        check("t6_done_illegal", done_a, 1);
        check("t6_count3", cnt_a, 0);
`else
        send(0, 4'h7, 3'd2, 3'd5, 6'h0, 9'h0AB, 1'b1, 1'b1, 1'b1);
        check("t6_we", we_a, 1);
        check("t6_wdata", wdata_a, 16'h74AB);
        check("t6_err", err_a, 0);
        check("t6_count", cnt_a, 1);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("q_a_empty", q_a.size(), 0);
        check("q_b_empty", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
